// File: rtl/mmc24_latch_mapper.sv
// Latch-switched CHR mapper covering MMC2 (PRG_MODE=0) and MMC4 (PRG_MODE=1); combinational address map, 1-clk latch update, no backpressure.
// Optional PRG RAM at $6000-7FFF with write protect when MMC24_PRG_RAM_EN is defined.
module mmc24_latch_mapper #(
  parameter int PRG_MODE         = 0,
  parameter int PRG_BANK_W       = 4,
  parameter int CHR_BANK_W       = 5,
  parameter int SSREG_INDEX_MAP1 = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        enable,
  input  logic [31:0] flags,
  input  logic [15:0] prg_ain,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  inout  wire  [21:0] prg_aout_b,
  inout  wire         prg_allow_b,
  inout  wire  [7:0]  prg_dout_b,
  input  logic [13:0] chr_ain,
  input  logic [13:0] chr_ain_o,
  input  logic        chr_read,
  input  logic        paused,
  inout  wire  [21:0] chr_aout_b,
  inout  wire         chr_allow_b,
  inout  wire         vram_a10_b,
  inout  wire         vram_ce_b,
  inout  wire         irq_b,
  input  logic [15:0] audio_in,
  inout  wire  [15:0] audio_b,
  inout  wire  [15:0] flags_out_b,
  input  logic [63:0] SaveStateBus_Din,
  input  logic [9:0]  SaveStateBus_Adr,
  input  logic        SaveStateBus_wren,
  input  logic        SaveStateBus_rst,
  input  logic        SaveStateBus_load,
  output logic [63:0] SaveStateBus_Dout
);

  logic [PRG_BANK_W-1:0] prg_bank_q, prg_bank_d;
  logic [CHR_BANK_W-1:0] chr0a_q, chr0a_d;
  logic [CHR_BANK_W-1:0] chr0b_q, chr0b_d;
  logic [CHR_BANK_W-1:0] chr1a_q, chr1a_d;
  logic [CHR_BANK_W-1:0] chr1b_q, chr1b_d;
  logic                  mirr_q, mirr_d;
  logic                  latch0_q, latch0_d;
  logic                  latch1_q, latch1_d;
  logic                  wp_q, wp_d;
  logic                  rd_q;
  logic [63:0]           ss_q;
  logic [63:0]           ss_word;

  logic reg_wr;
  logic trig;
  logic l0_fd, l0_fe, l1_fd, l1_fe;

  assign reg_wr = ce & prg_write & prg_ain[15];
  assign trig   = chr_read & ~rd_q & ~paused;

  assign l1_fd = (chr_ain_o[13:3] == 11'h3FB);
  assign l1_fe = (chr_ain_o[13:3] == 11'h3FD);

  // MMC4 matches the whole 8-byte tile row; MMC2 only the exact fetch address.
  always_comb begin
    if (PRG_MODE == 1) begin
      l0_fd = (chr_ain_o[13:3] == 11'h1FB);
      l0_fe = (chr_ain_o[13:3] == 11'h1FD);
    end else begin
      l0_fd = (chr_ain_o == 14'h0FD8);
      l0_fe = (chr_ain_o == 14'h0FE8);
    end
  end

  always_comb begin
    prg_bank_d = prg_bank_q;
    chr0a_d    = chr0a_q;
    chr0b_d    = chr0b_q;
    chr1a_d    = chr1a_q;
    chr1b_d    = chr1b_q;
    mirr_d     = mirr_q;
    latch0_d   = latch0_q;
    latch1_d   = latch1_q;
    wp_d       = wp_q;
    if (SaveStateBus_load) begin
      prg_bank_d = ss_q[PRG_BANK_W-1:0];
      chr0a_d    = ss_q[4  +: CHR_BANK_W];
      chr0b_d    = ss_q[12 +: CHR_BANK_W];
      chr1a_d    = ss_q[20 +: CHR_BANK_W];
      chr1b_d    = ss_q[28 +: CHR_BANK_W];
      mirr_d     = ss_q[36];
      latch0_d   = ss_q[37];
      latch1_d   = ss_q[38];
`ifdef MMC24_PRG_RAM_EN
      wp_d       = ss_q[39];
`endif
    end else begin
      if (reg_wr) begin
        case (prg_ain[14:12])
          3'd2: begin
            prg_bank_d = prg_din[PRG_BANK_W-1:0];
`ifdef MMC24_PRG_RAM_EN
            wp_d       = prg_din[7];
`endif
          end
          3'd3:    chr0a_d = prg_din[CHR_BANK_W-1:0];
          3'd4:    chr0b_d = prg_din[CHR_BANK_W-1:0];
          3'd5:    chr1a_d = prg_din[CHR_BANK_W-1:0];
          3'd6:    chr1b_d = prg_din[CHR_BANK_W-1:0];
          3'd7:    mirr_d  = prg_din[0];
          default: ;
        endcase
      end
      if (trig) begin
        if (l0_fd)      latch0_d = 1'b0;
        else if (l0_fe) latch0_d = 1'b1;
        if (l1_fd)      latch1_d = 1'b0;
        else if (l1_fe) latch1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      prg_bank_q <= '0;
      chr0a_q    <= '0;
      chr0b_q    <= '0;
      chr1a_q    <= '0;
      chr1b_q    <= '0;
      mirr_q     <= 1'b0;
      latch0_q   <= 1'b0;
      latch1_q   <= 1'b0;
      wp_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      prg_bank_q <= prg_bank_d;
      chr0a_q    <= chr0a_d;
      chr0b_q    <= chr0b_d;
      chr1a_q    <= chr1a_d;
      chr1b_q    <= chr1b_d;
      mirr_q     <= mirr_d;
      latch0_q   <= latch0_d;
      latch1_q   <= latch1_d;
      wp_q       <= wp_d;
      rd_q       <= chr_read;
    end
  end

  // Holding register for the savestate image; survives mapper reset so a load can follow it.
  always_ff @(posedge clk) begin
    if (SaveStateBus_rst) begin
      ss_q <= '0;
    end else if (SaveStateBus_wren && (SaveStateBus_Adr == 10'(SSREG_INDEX_MAP1))) begin
      ss_q <= SaveStateBus_Din;
    end
  end

  always_comb begin
    ss_word                     = '0;
    ss_word[PRG_BANK_W-1:0]     = prg_bank_q;
    ss_word[4  +: CHR_BANK_W]   = chr0a_q;
    ss_word[12 +: CHR_BANK_W]   = chr0b_q;
    ss_word[20 +: CHR_BANK_W]   = chr1a_q;
    ss_word[28 +: CHR_BANK_W]   = chr1b_q;
    ss_word[36]                 = mirr_q;
    ss_word[37]                 = latch0_q;
    ss_word[38]                 = latch1_q;
`ifdef MMC24_PRG_RAM_EN
    ss_word[39]                 = wp_q;
`endif
  end

  assign SaveStateBus_Dout = (enable && (SaveStateBus_Adr == 10'(SSREG_INDEX_MAP1))) ? ss_word : 64'd0;

  logic [PRG_BANK_W-1:0] prg_sel;
  logic [21:0]           prg_aout_v;
  logic                  prg_allow_v;

  always_comb begin
    if (PRG_MODE == 1) begin
      prg_sel    = prg_ain[14] ? {PRG_BANK_W{1'b1}} : prg_bank_q;
      prg_aout_v = 22'({prg_sel, prg_ain[13:0]});
    end else begin
      prg_sel    = (prg_ain[14:13] == 2'b00) ? prg_bank_q
                                             : {{(PRG_BANK_W-2){1'b1}}, prg_ain[14:13]};
      prg_aout_v = 22'({prg_sel, prg_ain[12:0]});
    end
    prg_allow_v = prg_ain[15] & ~prg_write;
`ifdef MMC24_PRG_RAM_EN
    if (prg_ain[15:13] == 3'b011) begin
      prg_aout_v  = {9'b111100000, prg_ain[12:0]};
      prg_allow_v = ~(prg_write & wp_q);
    end
`endif
  end

  logic [CHR_BANK_W-1:0] chrsel;
  logic [21:0]           chr_aout_v;

  always_comb begin
    if (chr_ain[12]) chrsel = latch1_q ? chr1b_q : chr1a_q;
    else             chrsel = latch0_q ? chr0b_q : chr0a_q;
    chr_aout_v = {10'b1000000000 | 10'(chrsel), chr_ain[11:0]};
  end

  assign prg_aout_b  = enable ? prg_aout_v : 22'bz;
  assign prg_allow_b = enable ? prg_allow_v : 1'bz;
  assign prg_dout_b  = enable ? 8'hFF : 8'bz;
  assign chr_aout_b  = enable ? chr_aout_v : 22'bz;
  assign chr_allow_b = enable ? flags[15] : 1'bz;
  assign vram_a10_b  = enable ? (mirr_q ? chr_ain[11] : chr_ain[10]) : 1'bz;
  assign vram_ce_b   = enable ? chr_ain[13] : 1'bz;
  assign irq_b       = enable ? 1'b0 : 1'bz;
  assign audio_b     = enable ? {1'b0, audio_in[15:1]} : 16'bz;
  assign flags_out_b = enable ? 16'h0008 : 16'bz;

  logic unused_bits;
  assign unused_bits = ^{flags, prg_din, chr_ain_o, audio_in[0], ss_q, wp_q};

endmodule

// File: tb/tb_mmc24_latch_mapper.sv
// Directed bench for both PRG layouts: dut0 is MMC2 (PRG_MODE=0), dut1 is MMC4 (PRG_MODE=1), sharing all inputs.
module tb_mmc24_latch_mapper;

  logic        clk = 1'b0;
  logic        reset, ce, enable, prg_write, chr_read, paused;
  logic [31:0] flags;
  logic [15:0] prg_ain, audio_in;
  logic [7:0]  prg_din;
  logic [13:0] chr_ain, chr_ain_o;
  logic [63:0] ss_din;
  logic [9:0]  ss_adr;
  logic        ss_wren, ss_rst, ss_load;

  wire  [21:0] w0_prg_aout, w1_prg_aout, w0_chr_aout, w1_chr_aout;
  wire         w0_prg_allow, w1_prg_allow, w0_chr_allow, w1_chr_allow;
  wire  [7:0]  w0_prg_dout, w1_prg_dout;
  wire         w0_a10, w1_a10, w0_vce, w1_vce, w0_irq, w1_irq;
  wire  [15:0] w0_audio, w1_audio, w0_fout, w1_fout;
  logic [63:0] w0_ss_dout, w1_ss_dout;

  pullup pu_irq (w0_irq);
  pullup pu_pa  (w0_prg_allow);
  pullup pu_ca  (w0_chr_allow);

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmc24_latch_mapper #(.PRG_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .enable(enable), .flags(flags),
    .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
    .prg_aout_b(w0_prg_aout), .prg_allow_b(w0_prg_allow), .prg_dout_b(w0_prg_dout),
    .chr_ain(chr_ain), .chr_ain_o(chr_ain_o), .chr_read(chr_read), .paused(paused),
    .chr_aout_b(w0_chr_aout), .chr_allow_b(w0_chr_allow), .vram_a10_b(w0_a10),
    .vram_ce_b(w0_vce), .irq_b(w0_irq), .audio_in(audio_in), .audio_b(w0_audio),
    .flags_out_b(w0_fout), .SaveStateBus_Din(ss_din), .SaveStateBus_Adr(ss_adr),
    .SaveStateBus_wren(ss_wren), .SaveStateBus_rst(ss_rst), .SaveStateBus_load(ss_load),
    .SaveStateBus_Dout(w0_ss_dout)
  );

  mmc24_latch_mapper #(.PRG_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .enable(enable), .flags(flags),
    .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
    .prg_aout_b(w1_prg_aout), .prg_allow_b(w1_prg_allow), .prg_dout_b(w1_prg_dout),
    .chr_ain(chr_ain), .chr_ain_o(chr_ain_o), .chr_read(chr_read), .paused(paused),
    .chr_aout_b(w1_chr_aout), .chr_allow_b(w1_chr_allow), .vram_a10_b(w1_a10),
    .vram_ce_b(w1_vce), .irq_b(w1_irq), .audio_in(audio_in), .audio_b(w1_audio),
    .flags_out_b(w1_fout), .SaveStateBus_Din(ss_din), .SaveStateBus_Adr(ss_adr),
    .SaveStateBus_wren(ss_wren), .SaveStateBus_rst(ss_rst), .SaveStateBus_load(ss_load),
    .SaveStateBus_Dout(w1_ss_dout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    prg_ain = a; prg_din = d; prg_write = 1'b1; ce = 1'b1;
    tick();
    ce = 1'b0; prg_write = 1'b0;
  endtask

  task automatic strobe(input logic [13:0] a);
    chr_ain_o = a; chr_read = 1'b1;
    tick();
    chr_read = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; enable = 1'b1; prg_write = 1'b0; chr_read = 1'b0; paused = 1'b0;
    flags = 32'h0; prg_ain = 16'h0; audio_in = 16'hA5A5; prg_din = 8'h0;
    chr_ain = 14'h0; chr_ain_o = 14'h0; ss_din = 64'h0; ss_adr = 10'd32;
    ss_wren = 1'b0; ss_rst = 1'b1; ss_load = 1'b0;
    tick(); tick();
    reset = 1'b0; ss_rst = 1'b0;
    #1;

    // Reset state and fixed outputs
    chk("rst_chr",   64'(w0_chr_aout), 64'h200000);
    chk("rst_ss",    w0_ss_dout, 64'h0);
    chk("rst_irq",   64'(w0_irq), 64'h0);
    chk("rst_fout",  64'(w0_fout), 64'h0008);
    chk("prg_dout",  64'(w0_prg_dout), 64'hFF);
    chk("audio",     64'(w0_audio), 64'h52D2);
    chk("chr_allow0", 64'(w0_chr_allow), 64'h0);
    flags = 32'h0000_8000; #1;
    chr_ain = 14'h0;
    chk("chr_allow1", 64'(w0_chr_allow), 64'h1);
    flags = 32'h0;

    // PRG mapping, MMC2 and MMC4
    wr(16'hA000, 8'h05);
    prg_ain = 16'h8123; #1;
    chk("m0_8123",   64'(w0_prg_aout), 64'h00A123);
    chk("m0_allow",  64'(w0_prg_allow), 64'h1);
    prg_ain = 16'hE000; #1;
    chk("m0_E000",   64'(w0_prg_aout), 64'h01E000);
    wr(16'hA000, 8'h03);
    prg_ain = 16'h8001; #1;
    chk("m1_8001",   64'(w1_prg_aout), 64'h00C001);
    prg_ain = 16'hC000; #1;
    chk("m1_C000",   64'(w1_prg_aout), 64'h03C000);
    prg_ain = 16'h8123; #1;
    chk("m0_8123b",  64'(w0_prg_aout), 64'h006123);
    prg_write = 1'b1; #1;
    chk("wr_allow",  64'(w0_prg_allow), 64'h0);
    prg_write = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    prg_ain = 16'h8001; #1;
    chk("m1_rst",    64'(w1_prg_aout), 64'h000001);

    // Latch 0 trigger: old bank on the triggering fetch, new bank next clk, one update per strobe
    wr(16'hB000, 8'h02);
    wr(16'hC000, 8'h09);
    chr_ain = 14'h0FE8; chr_ain_o = 14'h0FE8; chr_read = 1'b1; #1;
    chk("trig_old",  64'(w0_chr_aout), 64'h202FE8);
    tick();
    chr_ain = 14'h0000; chr_ain_o = 14'h0FD8; #1;
    chk("trig_new",  64'(w0_chr_aout), 64'h209000);
    tick(); tick();
    chr_read = 1'b0; tick();
    chk("held_m0",   64'(w0_chr_aout), 64'h209000);
    chk("held_m1",   64'(w1_chr_aout), 64'h209000);

    // Latch 0 decode range: exact for MMC2, tile row for MMC4
    strobe(14'h0FD8);
    chk("fd_m0",     64'(w0_chr_aout), 64'h202000);
    strobe(14'h0FE9);
    chk("fe9_m0",    64'(w0_chr_aout), 64'h202000);
    chk("fe9_m1",    64'(w1_chr_aout), 64'h209000);

    // Latch 1 and pause
    wr(16'hD000, 8'h13);
    wr(16'hE000, 8'h1C);
    chr_ain = 14'h1000; #1;
    chk("l1_a",      64'(w0_chr_aout), 64'h213000);
    paused = 1'b1;
    strobe(14'h1FE8);
    paused = 1'b0;
    chk("paused",    64'(w0_chr_aout), 64'h213000);
    strobe(14'h1FE8);
    chk("l1_b",      64'(w0_chr_aout), 64'h21C000);
    strobe(14'h0FE8);
    chr_ain = 14'h0000; #1;
    chk("l0_again",  64'(w0_chr_aout), 64'h209000);

    // Mirroring
    chr_ain = 14'h2400; #1;
    chk("a10_h",     64'(w0_a10), 64'h1);
    chk("vce",       64'(w0_vce), 64'h1);
    wr(16'hF000, 8'h01);
    chr_ain = 14'h2800; #1;
    chk("a10_v1",    64'(w0_a10), 64'h1);
    chr_ain = 14'h2400; #1;
    chk("a10_v0",    64'(w0_a10), 64'h0);

    // Savestate: save, alter, load (with a concurrent latch edge that must be discarded)
    wr(16'hA000, 8'h05);
    chk("ss_m0",     w0_ss_dout, 64'h0000_0071_C130_9025);
    chk("ss_m1",     w1_ss_dout, 64'h0000_0071_C130_9025);
    ss_din = 64'h0000_0071_C130_9025; ss_wren = 1'b1; tick(); ss_wren = 1'b0;
    wr(16'hA000, 8'h0A);
    wr(16'hB000, 8'h01);
    wr(16'hC000, 8'h01);
    wr(16'hD000, 8'h01);
    wr(16'hE000, 8'h01);
    wr(16'hF000, 8'h00);
    strobe(14'h0FD8);
    strobe(14'h1FD8);
    chk("ss_alt",    w0_ss_dout, 64'h0000_0000_1010_101A);
    chr_ain_o = 14'h0FD8; chr_read = 1'b1; ss_load = 1'b1;
    tick();
    ss_load = 1'b0; chr_read = 1'b0;
    tick();
    chk("ss_ld_m0",  w0_ss_dout, 64'h0000_0071_C130_9025);
    chk("ss_ld_m1",  w1_ss_dout, 64'h0000_0071_C130_9025);
    chr_ain = 14'h0000; prg_ain = 16'h8001; #1;
    chk("ld_chr",    64'(w0_chr_aout), 64'h209000);
    chk("ld_prg",    64'(w1_prg_aout), 64'h014001);

    // PRG RAM window
    prg_ain = 16'h6000; #1;
`ifdef MMC24_PRG_RAM_EN
    chk("ram_rd",    64'(w0_prg_allow), 64'h1);
    chk("ram_addr",  64'(w0_prg_aout), 64'h3C0000);
    prg_write = 1'b1; #1;
    chk("ram_wr",    64'(w0_prg_allow), 64'h1);
    prg_write = 1'b0;
    wr(16'hA000, 8'h80);
    prg_ain = 16'h6000; prg_write = 1'b1; #1;
    chk("ram_wp_wr", 64'(w0_prg_allow), 64'h0);
    prg_write = 1'b0; #1;
    chk("ram_wp_rd", 64'(w0_prg_allow), 64'h1);
`else
    chk("ram_none",  64'(w0_prg_allow), 64'h0);
`endif

    // Disable: outputs released, state held in reset
    prg_ain = 16'h8000; prg_write = 1'b1; flags = 32'h0;
    enable = 1'b0; tick();
    chk("dis_irq",   64'(w0_irq), 64'h1);
    chk("dis_pallow", 64'(w0_prg_allow), 64'h1);
    chk("dis_callow", 64'(w0_chr_allow), 64'h1);
    chk("dis_ss",    w0_ss_dout, 64'h0);
    prg_write = 1'b0;
    enable = 1'b1; #1;
    chk("en_ss",     w1_ss_dout, 64'h0);
    chk("en_irq",    64'(w0_irq), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
